// File: rtl/status_rmw_controller_pkg.sv
// Shared parameters and types for the status-row read-modify-write controller.
// Row layout: block b occupies bits [2b+1:2b] = {recent, valid}.
package status_rmw_controller_pkg;

    localparam int NUM_BLOCKS      = 4;
    localparam int ADDR_WIDTH      = 6;
    localparam int ROW_WIDTH       = 2 * NUM_BLOCKS;
    localparam int BLOCK_IDX_WIDTH = $clog2(NUM_BLOCKS);

    localparam int STAT_VALID_BIT  = 0;
    localparam int STAT_RECENT_BIT = 1;

    localparam logic OP_ALLOCATE   = 1'b0;
    localparam logic OP_INVALIDATE = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD_REQ,
        ST_RD_WAIT,
        ST_WR_REQ,
        ST_RESP
    } rmw_state_t;

endpackage

// File: rtl/status_victim_select.sv
// Combinational allocation policy: picks a victim block from an old status row
// and produces the updated row with the victim marked valid and recent.
module status_victim_select
    import status_rmw_controller_pkg::*;
(
    input  logic [ROW_WIDTH-1:0]       old_row,
    output logic [BLOCK_IDX_WIDTH-1:0] victim,
    output logic                       was_full,
    output logic [ROW_WIDTH-1:0]       new_row
);

    logic [NUM_BLOCKS-1:0]      valid;
    logic [NUM_BLOCKS-1:0]      recent;
    logic [NUM_BLOCKS-1:0]      hit;
    logic [NUM_BLOCKS-1:0]      new_valid;
    logic [NUM_BLOCKS-1:0]      new_recent;
    logic [BLOCK_IDX_WIDTH-1:0] free_idx;
    logic [BLOCK_IDX_WIDTH-1:0] stale_idx;
    logic                       have_free;
    logic                       have_stale;

    always_comb begin
        valid      = '0;
        recent     = '0;
        free_idx   = '0;
        stale_idx  = '0;
        have_free  = 1'b0;
        have_stale = 1'b0;
        new_row    = '0;

        for (int i = 0; i < NUM_BLOCKS; i++) begin
            valid[i]  = old_row[2*i + STAT_VALID_BIT];
            recent[i] = old_row[2*i + STAT_RECENT_BIT];
        end

        // Scan downward so the last hit recorded is the lowest index.
        for (int i = NUM_BLOCKS - 1; i >= 0; i--) begin
            if (!valid[i]) begin
                have_free = 1'b1;
                free_idx  = BLOCK_IDX_WIDTH'(i);
            end
            if (!recent[i]) begin
                have_stale = 1'b1;
                stale_idx  = BLOCK_IDX_WIDTH'(i);
            end
        end

        if (have_free) begin
            victim = free_idx;
        end else if (have_stale) begin
            victim = stale_idx;
        end else begin
            victim = '0;
        end

        hit        = NUM_BLOCKS'(1) << victim;
        new_valid  = valid | hit;
        new_recent = recent | hit;
        // Once every block looks recent, restart the epoch keeping only the victim.
        if (&new_recent) begin
            new_recent = hit;
        end

        for (int i = 0; i < NUM_BLOCKS; i++) begin
            new_row[2*i + STAT_VALID_BIT]  = new_valid[i];
            new_row[2*i + STAT_RECENT_BIT] = new_recent[i];
        end

        was_full = &valid;
    end

endmodule

// File: rtl/status_rmw_controller.sv
// Read-modify-write sequencer in front of the status array: reads a row,
// applies an allocate or invalidate update, writes it back and reports the block.
module status_rmw_controller
    import status_rmw_controller_pkg::*;
#(
    parameter int TAG_WIDTH = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_halt,
    input  logic                       i_valid,
    output logic                       o_ready,
    input  logic                       i_op,
    input  logic [ADDR_WIDTH-1:0]      i_addr,
    input  logic [BLOCK_IDX_WIDTH-1:0] i_block,
    output logic                       o_resp_valid,
    input  logic                       i_resp_ready,
    output logic [BLOCK_IDX_WIDTH-1:0] o_resp_block,
    output logic                       o_resp_was_full,
    output logic [TAG_WIDTH-1:0]       o_sa_tag,
    output logic [ADDR_WIDTH-1:0]      o_sa_addr,
    output logic [ROW_WIDTH-1:0]       o_sa_data,
    output logic                       o_sa_wen,
    output logic [NUM_BLOCKS-1:0]      o_sa_wmask,
    output logic                       o_sa_valid,
    input  logic                       i_sa_ready,
    input  logic [TAG_WIDTH-1:0]       i_sa_tag,
    input  logic [ROW_WIDTH-1:0]       i_sa_data,
    input  logic                       i_sa_valid
);

    rmw_state_t                 state, state_n;
    logic [TAG_WIDTH-1:0]       seq, seq_n;

    logic                       cur_op, cur_op_n;
    logic [ADDR_WIDTH-1:0]      cur_addr, cur_addr_n;
    logic [BLOCK_IDX_WIDTH-1:0] cur_block, cur_block_n;
    logic [BLOCK_IDX_WIDTH-1:0] res_block, res_block_n;
    logic                       res_full, res_full_n;

    logic                       sa_valid_n;
    logic                       sa_wen_n;
    logic [TAG_WIDTH-1:0]       sa_tag_n;
    logic [ADDR_WIDTH-1:0]      sa_addr_n;
    logic [ROW_WIDTH-1:0]       sa_data_n;
    logic [NUM_BLOCKS-1:0]      sa_wmask_n;
    logic                       resp_valid_n;
    logic [BLOCK_IDX_WIDTH-1:0] resp_block_n;
    logic                       resp_full_n;

    logic [BLOCK_IDX_WIDTH-1:0] alloc_block;
    logic                       alloc_full;
    logic [ROW_WIDTH-1:0]       alloc_row;
    logic [ROW_WIDTH-1:0]       inv_row;
    logic [NUM_BLOCKS-1:0]      inv_mask;

    status_victim_select u_victim (
        .old_row  (i_sa_data),
        .victim   (alloc_block),
        .was_full (alloc_full),
        .new_row  (alloc_row)
    );

    // Invalidate clears only the target block; the rest of the row is the old data.
    assign inv_row  = i_sa_data & ~(ROW_WIDTH'(2'b11) << {cur_block, 1'b0});
    assign inv_mask = NUM_BLOCKS'(1) << cur_block;

    // Halt does not gate ready: the state register ignores the accept while halted.
    assign o_ready = (state == ST_IDLE) && !rst;

    always_comb begin
        state_n      = state;
        seq_n        = seq;
        cur_op_n     = cur_op;
        cur_addr_n   = cur_addr;
        cur_block_n  = cur_block;
        res_block_n  = res_block;
        res_full_n   = res_full;
        sa_valid_n   = o_sa_valid;
        sa_wen_n     = o_sa_wen;
        sa_tag_n     = o_sa_tag;
        sa_addr_n    = o_sa_addr;
        sa_data_n    = o_sa_data;
        sa_wmask_n   = o_sa_wmask;
        resp_valid_n = o_resp_valid;
        resp_block_n = o_resp_block;
        resp_full_n  = o_resp_was_full;

        case (state)
            ST_IDLE: begin
                if (i_valid) begin
                    state_n     = ST_RD_REQ;
                    cur_op_n    = i_op;
                    cur_addr_n  = i_addr;
                    cur_block_n = i_block;
                    sa_valid_n  = 1'b1;
                    sa_wen_n    = 1'b0;
                    sa_tag_n    = seq;
                    sa_addr_n   = i_addr;
                    sa_data_n   = '0;
                    sa_wmask_n  = '0;
                end
            end
            ST_RD_REQ: begin
                if (i_sa_ready) begin
                    state_n    = ST_RD_WAIT;
                    sa_valid_n = 1'b0;
                end
            end
            ST_RD_WAIT: begin
                if (i_sa_valid && (i_sa_tag == seq)) begin
                    state_n    = ST_WR_REQ;
                    seq_n      = seq + TAG_WIDTH'(1);
                    sa_valid_n = 1'b1;
                    sa_wen_n   = 1'b1;
                    sa_addr_n  = cur_addr;
                    if (cur_op == OP_ALLOCATE) begin
                        sa_data_n   = alloc_row;
                        sa_wmask_n  = '1;
                        res_block_n = alloc_block;
                        res_full_n  = alloc_full;
                    end else begin
                        sa_data_n   = inv_row;
                        sa_wmask_n  = inv_mask;
                        res_block_n = cur_block;
                        res_full_n  = 1'b0;
                    end
                end
            end
            ST_WR_REQ: begin
                if (i_sa_ready) begin
                    state_n      = ST_RESP;
                    sa_valid_n   = 1'b0;
                    sa_wen_n     = 1'b0;
                    resp_valid_n = 1'b1;
                    resp_block_n = res_block;
                    resp_full_n  = res_full;
                end
            end
            ST_RESP: begin
                if (i_resp_ready) begin
                    state_n      = ST_IDLE;
                    resp_valid_n = 1'b0;
                end
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= ST_IDLE;
            seq             <= '0;
            o_sa_valid      <= 1'b0;
            o_sa_wen        <= 1'b0;
            o_sa_tag        <= '0;
            o_sa_addr       <= '0;
            o_sa_data       <= '0;
            o_sa_wmask      <= '0;
            o_resp_valid    <= 1'b0;
            o_resp_block    <= '0;
            o_resp_was_full <= 1'b0;
        end else if (!i_halt) begin
            state           <= state_n;
            seq             <= seq_n;
            cur_op          <= cur_op_n;
            cur_addr        <= cur_addr_n;
            cur_block       <= cur_block_n;
            res_block       <= res_block_n;
            res_full        <= res_full_n;
            o_sa_valid      <= sa_valid_n;
            o_sa_wen        <= sa_wen_n;
            o_sa_tag        <= sa_tag_n;
            o_sa_addr       <= sa_addr_n;
            o_sa_data       <= sa_data_n;
            o_sa_wmask      <= sa_wmask_n;
            o_resp_valid    <= resp_valid_n;
            o_resp_block    <= resp_block_n;
            o_resp_was_full <= resp_full_n;
        end
    end

endmodule

// File: tb/tb_status_rmw_controller.sv
// Directed bench for status_rmw_controller: allocate/invalidate row updates,
// stale-tag rejection, halt freezing and mid-operation reset.
module tb_status_rmw_controller;
    import status_rmw_controller_pkg::*;

    localparam int TW = 2;

    logic                       clk = 1'b0;
    logic                       rst = 1'b1;
    logic                       i_halt = 1'b0;
    logic                       i_valid = 1'b0;
    logic                       o_ready;
    logic                       i_op = 1'b0;
    logic [ADDR_WIDTH-1:0]      i_addr = '0;
    logic [BLOCK_IDX_WIDTH-1:0] i_block = '0;
    logic                       o_resp_valid;
    logic                       i_resp_ready = 1'b0;
    logic [BLOCK_IDX_WIDTH-1:0] o_resp_block;
    logic                       o_resp_was_full;
    logic [TW-1:0]              o_sa_tag;
    logic [ADDR_WIDTH-1:0]      o_sa_addr;
    logic [ROW_WIDTH-1:0]       o_sa_data;
    logic                       o_sa_wen;
    logic [NUM_BLOCKS-1:0]      o_sa_wmask;
    logic                       o_sa_valid;
    logic                       i_sa_ready = 1'b0;
    logic [TW-1:0]              i_sa_tag = '0;
    logic [ROW_WIDTH-1:0]       i_sa_data = '0;
    logic                       i_sa_valid = 1'b0;

    int            checks = 0;
    int            errors = 0;
    logic [TW-1:0] exp_seq = '0;

    status_rmw_controller #(.TAG_WIDTH(TW)) dut (
        .clk             (clk),
        .rst             (rst),
        .i_halt          (i_halt),
        .i_valid         (i_valid),
        .o_ready         (o_ready),
        .i_op            (i_op),
        .i_addr          (i_addr),
        .i_block         (i_block),
        .o_resp_valid    (o_resp_valid),
        .i_resp_ready    (i_resp_ready),
        .o_resp_block    (o_resp_block),
        .o_resp_was_full (o_resp_was_full),
        .o_sa_tag        (o_sa_tag),
        .o_sa_addr       (o_sa_addr),
        .o_sa_data       (o_sa_data),
        .o_sa_wen        (o_sa_wen),
        .o_sa_wmask      (o_sa_wmask),
        .o_sa_valid      (o_sa_valid),
        .i_sa_ready      (i_sa_ready),
        .i_sa_tag        (i_sa_tag),
        .i_sa_data       (i_sa_data),
        .i_sa_valid      (i_sa_valid)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_req(input logic op, input logic [ADDR_WIDTH-1:0] addr,
                            input logic [BLOCK_IDX_WIDTH-1:0] blk);
        chk("idle_ready", 32'(o_ready), 32'd1);
        i_valid = 1'b1;
        i_op    = op;
        i_addr  = addr;
        i_block = blk;
        step();
        i_valid = 1'b0;
        chk("rd_valid", 32'(o_sa_valid), 32'd1);
        chk("rd_wen",   32'(o_sa_wen),   32'd0);
        chk("rd_addr",  32'(o_sa_addr),  32'(addr));
        chk("rd_tag",   32'(o_sa_tag),   32'(exp_seq));
        chk("busy_ready", 32'(o_ready),  32'd0);
    endtask

    task automatic accept_sa();
        i_sa_ready = 1'b1;
        step();
        i_sa_ready = 1'b0;
    endtask

    task automatic return_row(input logic [TW-1:0] tag, input logic [ROW_WIDTH-1:0] row);
        i_sa_valid = 1'b1;
        i_sa_tag   = tag;
        i_sa_data  = row;
        step();
        i_sa_valid = 1'b0;
        i_sa_data  = '0;
    endtask

    task automatic read_phase(input logic [ROW_WIDTH-1:0] row);
        accept_sa();
        chk("rdwait_valid", 32'(o_sa_valid), 32'd0);
        return_row(exp_seq, row);
        exp_seq = exp_seq + 1'b1;
    endtask

    task automatic check_write(input logic [ROW_WIDTH-1:0] data, input logic [NUM_BLOCKS-1:0] mask);
        chk("wr_valid", 32'(o_sa_valid), 32'd1);
        chk("wr_wen",   32'(o_sa_wen),   32'd1);
        chk("wr_data",  32'(o_sa_data),  32'(data));
        chk("wr_mask",  32'(o_sa_wmask), 32'(mask));
    endtask

    task automatic check_resp(input logic [BLOCK_IDX_WIDTH-1:0] blk, input logic full);
        chk("resp_valid", 32'(o_resp_valid),    32'd1);
        chk("resp_block", 32'(o_resp_block),    32'(blk));
        chk("resp_full",  32'(o_resp_was_full), 32'(full));
        chk("resp_sa_idle", 32'(o_sa_valid),    32'd0);
        step();
        chk("resp_hold", 32'(o_resp_valid), 32'd1);
        i_resp_ready = 1'b1;
        step();
        i_resp_ready = 1'b0;
        chk("resp_done", 32'(o_resp_valid), 32'd0);
    endtask

    task automatic do_rmw(input logic op, input logic [ADDR_WIDTH-1:0] addr,
                          input logic [BLOCK_IDX_WIDTH-1:0] blk, input logic [ROW_WIDTH-1:0] row,
                          input logic [ROW_WIDTH-1:0] wdata, input logic [NUM_BLOCKS-1:0] wmask,
                          input logic [BLOCK_IDX_WIDTH-1:0] rblk, input logic rfull);
        send_req(op, addr, blk);
        read_phase(row);
        check_write(wdata, wmask);
        accept_sa();
        check_resp(rblk, rfull);
    endtask

    initial begin
        // Reset state
        step();
        step();
        chk("rst_ready",      32'(o_ready),      32'd0);
        chk("rst_sa_valid",   32'(o_sa_valid),   32'd0);
        chk("rst_resp_valid", 32'(o_resp_valid), 32'd0);
        chk("rst_sa_data",    32'(o_sa_data),    32'd0);
        rst = 1'b0;
        step();
        chk("post_rst_ready", 32'(o_ready), 32'd1);

        // Allocation policy and invalidate vectors
        do_rmw(OP_ALLOCATE,   6'd5,  2'd0, 8'h00, 8'h03, 4'b1111, 2'd0, 1'b0);
        do_rmw(OP_ALLOCATE,   6'd7,  2'd0, 8'h57, 8'h5F, 4'b1111, 2'd1, 1'b1);
        do_rmw(OP_ALLOCATE,   6'd12, 2'd0, 8'h7F, 8'hD5, 4'b1111, 2'd3, 1'b1);
        do_rmw(OP_INVALIDATE, 6'd3,  2'd2, 8'hFF, 8'hCF, 4'b0100, 2'd2, 1'b0);

        // Stale tag ignored, then halt in WR_REQ with ready asserted
        send_req(OP_ALLOCATE, 6'd9, 2'd0);
        accept_sa();
        return_row(exp_seq + 1'b1, 8'hFF);
        chk("stale_sa_valid",   32'(o_sa_valid),   32'd0);
        chk("stale_resp_valid", 32'(o_resp_valid), 32'd0);
        return_row(exp_seq, 8'h00);
        exp_seq = exp_seq + 1'b1;
        check_write(8'h03, 4'b1111);
        i_halt     = 1'b1;
        i_sa_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            chk("halt_sa_valid",   32'(o_sa_valid),   32'd1);
            chk("halt_resp_valid", 32'(o_resp_valid), 32'd0);
        end
        i_halt = 1'b0;
        step();
        i_sa_ready = 1'b0;
        check_resp(2'd0, 1'b0);
        chk("halt_single_write", 32'(o_sa_valid), 32'd0);

        // Reset during WR_REQ drops the request
        send_req(OP_ALLOCATE, 6'd20, 2'd0);
        read_phase(8'h00);
        check_write(8'h03, 4'b1111);
        rst = 1'b1;
        step();
        chk("mrst_sa_valid", 32'(o_sa_valid), 32'd0);
        chk("mrst_ready",    32'(o_ready),    32'd0);
        rst     = 1'b0;
        exp_seq = '0;
        step();
        chk("mrst_ready_after", 32'(o_ready), 32'd1);
        i_resp_ready = 1'b1;
        return_row(2'd1, 8'h00);
        chk("mrst_no_resp",    32'(o_resp_valid), 32'd0);
        chk("mrst_no_sa",      32'(o_sa_valid),   32'd0);
        step();
        i_resp_ready = 1'b0;
        chk("mrst_no_resp2",   32'(o_resp_valid), 32'd0);

        // First request after reset uses tag 0 again
        do_rmw(OP_INVALIDATE, 6'd33, 2'd1, 8'h3C, 8'h30, 4'b0010, 2'd1, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/status_rmw_controller.md
# status_rmw_controller

Read-modify-write sequencer that is the client side of the status array wrapper. It takes allocate and invalidate requests from the cache control path and reads the addressed status row. It selects a victim block or clears a block, writes the updated row back with a per-block write mask, and returns the chosen block index. It sits between the miss/flush logic and the status array wrapper, and is the only agent driving the wrapper's request port after initialization completes.

## Interface
- `TAG_WIDTH`, 2: width of the read-sequence tag sent to, and returned by, the status array.
- `ADDR_WIDTH`, `ROW_WIDTH`, `NUM_BLOCKS`: taken from the shared params, not overridable here.
- Reset is synchronous and active-high.
- Signals:
  - `clk`  in  1  single clock; all state changes on rising edge.
  - `rst`  in  1  synchronous active-high reset.
  - `i_halt`  in  1  freezes all state and outputs while high.
  - `i_valid`  in  1  request valid.
  - `o_ready`  out  1  request accepted when `i_valid && o_ready`.
  - `i_op`  in  1  0 = ALLOCATE, 1 = INVALIDATE.
  - `i_addr`  in  `ADDR_WIDTH`  status row index.
  - `i_block`  in  `$clog2(NUM_BLOCKS)`  block to clear (INVALIDATE only).
  - `o_resp_valid`  out  1  response valid.
  - `i_resp_ready`  in  1  response consumed when `o_resp_valid && i_resp_ready`.
  - `o_resp_block`  out  `$clog2(NUM_BLOCKS)`  chosen/cleared block.
  - `o_resp_was_full`  out  1  ALLOCATE found all blocks valid.
  - `o_sa_tag`  out  `TAG_WIDTH`  status array request tag.
  - `o_sa_addr`  out  `ADDR_WIDTH`  status array request address.
  - `o_sa_data`  out  `ROW_WIDTH`  status array write data.
  - `o_sa_wen`  out  1  status array write enable.
  - `o_sa_wmask`  out  `NUM_BLOCKS`  status array write mask.
  - `o_sa_valid`  out  1  status array request valid.
  - `i_sa_ready`  in  1  request accepted when `o_sa_valid && i_sa_ready`.
  - `i_sa_tag`  in  `TAG_WIDTH`  returned read tag.
  - `i_sa_data`  in  `ROW_WIDTH`  returned row.
  - `i_sa_valid`  in  1  returned row valid.

## Operation
- Row layout: block b occupies bits [2b+1:2b] = {recent, valid}. `ROW_WIDTH = 2*NUM_BLOCKS`.
- FSM states: IDLE, RD_REQ, RD_WAIT, WR_REQ, RESP.
  - IDLE: `o_ready=1`. On accept, latch op/addr/block, go RD_REQ.
  - RD_REQ: drive `o_sa_valid=1`, `o_sa_wen=0`, `o_sa_tag=seq`. On `i_sa_ready`, go RD_WAIT.
  - RD_WAIT: wait for `i_sa_valid && i_sa_tag==seq`. Returns with a mismatched tag are ignored. On match, compute the new row, increment `seq` (mod 2^TAG_WIDTH), go WR_REQ.
  - WR_REQ: drive `o_sa_valid=1`, `o_sa_wen=1`, with data and mask. On `i_sa_ready`, go RESP.
  - RESP: `o_resp_valid=1`; hold the outputs stable until `i_resp_ready`, then go IDLE.
- ALLOCATE:
  - Victim is the lowest-index block with valid=0.
  - Otherwise, the victim is the lowest-index block with recent=0.
  - Otherwise the victim is block 0.
  - Set the victim to {1,1}.
  - If all recent bits are then 1, clear recent on every non-victim block.
  - Write mask is all ones.
  - `was_full` is the AND of the old valid bits.
- INVALIDATE:
  - Block `i_block` is written {0,0}.
  - Write mask is the one-hot of `i_block`.
  - The other data bits are don't-care; drive the old row.
  - `was_full=0`, `resp_block=i_block`.
- `o_ready=0` in every non-IDLE state; one request is in flight at a time.

## Timing
- `rst` has priority over `i_halt`.
- Reset values, applied the cycle after `rst` is sampled: state=IDLE, `seq=0`.
  - All outputs 0 except `o_ready`.
  - `o_ready` is 0 while `rst` is high and 1 the first cycle after it drops.
- Reset mid-operation: the in-flight request is dropped and no response is issued. A late array return is ignored because the state is IDLE.
- `i_halt` high: state, `seq` and all outputs hold their values. Handshakes are not evaluated.
- Minimum latency, accept to `o_resp_valid`, with a zero-stall array of read latency L: 3+L cycles.
  - accept → RD_REQ (1) → RD_WAIT (+1) → L → WR_REQ (+1) → RESP.
- `o_sa_*` outputs are registered and change only on state transitions.
- A row return arriving in the same cycle the read is accepted is not possible; RD_WAIT starts the cycle after acceptance.

## Structure
- Shared params header gains: `BLOCK_IDX_WIDTH = $clog2(NUM_BLOCKS)`, `STAT_VALID_BIT=0`, `STAT_RECENT_BIT=1`, and the op encodings `OP_ALLOCATE=1'b0`, `OP_INVALIDATE=1'b1`.
- One sub-module is natural: `status_victim_select`. It is purely combinational, maps old row → {victim, was_full, new row}, and is unit-testable alone.

## Test plan
- With `NUM_BLOCKS=4`, array returning 8'h00, ALLOCATE addr 5 → read at addr 5, then write data 8'h03 with mask 4'b1111; response block 0, `was_full=0`.
- ALLOCATE on row 8'h57 → write 8'h5F; response block 1, `was_full=1`.
- ALLOCATE on row 8'h7F → recent wrap; write 8'hD5; response block 3, `was_full=1`.
- INVALIDATE block 2 on row 8'hFF → write with `o_sa_wmask=4'b0100` and bits [5:4]=2'b00; response block 2, `was_full=0`.
- Stale/halt case:
  - Inject a return with the wrong tag in RD_WAIT → ignored, no state change.
  - Assert `i_halt` for 3 cycles in WR_REQ with `i_sa_ready=1` → no accept; the write occurs once after halt drops.
- Pulse `rst` during WR_REQ → next cycle `o_sa_valid=0`, `o_ready=1` after `rst` drops, and no `o_resp_valid` for the dropped request.
